addsub_result_fifo: RTL and testbench
=====================================

// Module: addsub_result_fifo
// PURPOSE
// - Result-capture stage directly downstream of the 4-bit adder/subtractor.
// - Accepts each {S, Cout, V} result under a valid/ready handshake.
// - Adds zero and negative flags to each result.
// - Buffers results in a DEPTH-entry FIFO and hands them to the consumer under valid/ready.
// - Keeps a sticky overflow flag and a saturating overflow-event counter.
// PARAMETERS
// DEPTH  4  FIFO entries; power of 2, >=2
// CNT_W  8  width of overflow event counter
// PORTS
// clk        in   1                 system clock, rising edge
// rst        in   1                 asynchronous, active-high reset
// in_valid   in   1                 adder result present on in_sum/in_cout/in_v
// in_ready   out  1                 FIFO can accept a result
// in_sum     in   4                 adder S[3:0]
// in_cout    in   1                 adder Cout
// in_v       in   1                 adder V (signed overflow)
// out_valid  out  1                 head entry valid
// out_ready  in   1                 consumer takes head entry
// out_sum    out  4                 head S
// out_cout   out  1                 head Cout
// out_v      out  1                 head V
// out_zero   out  1                 head S==4'b0000
// out_neg    out  1                 head S[3]
// level      out  $clog2(DEPTH)+1   occupied entries, 0..DEPTH
// ovf_sticky out  1                 set by any accepted result with V=1
// ovf_count  out  CNT_W             accepted results with V=1, saturating
// ovf_clr    in   1                 synchronous clear of ovf_sticky and ovf_count
// BEHAVIOUR
// - Clock and reset: one clock (clk); reset is asynchronous and active-high (rst).
// - Reset (async assert, sync release) returns every output to 0:
//   - in_ready returns 1 after reset.
//   - Storage contents are don't-care.
// - Storage: entry = {zero, neg, v, cout, sum[3:0]}, 8 bits.
//   - zero and neg are computed from in_sum at push time.
// - Push = in_valid & in_ready. Pop = out_valid & out_ready.
// - in_ready = (level != DEPTH).
//   - No full-bypass: when full, a push is refused even if a pop occurs in the same cycle.
// - out_valid = (level != 0).
//   - out_* reflect the head entry combinationally from registered storage.
//   - When empty, out_sum/cout/v/zero/neg are forced to 0.
// - Latency: a result pushed at edge n appears on out_* after edge n (1 cycle), if the FIFO was empty.
// - Pointers: wr_ptr/rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH.
//   - level tracks occupancy: +1 on push only, -1 on pop only, unchanged on both or neither.
// - Simultaneous push and pop when 0<level<DEPTH: both occur; level is unchanged.
// - Pop when empty and push when full are impossible by construction.
//   - out_ready and in_valid are ignored in those states.
// - Ordering: strict FIFO. Entries are never dropped or duplicated.
// - Overflow tracking counts on push, not pop:
//   - Accepted push with in_v=1 sets ovf_sticky.
//   - The same push increments ovf_count, which saturates at 2^CNT_W-1.
// - ovf_clr=1 clears ovf_sticky to 0 and ovf_count to 0.
//   - If the same cycle also has an accepted push with in_v=1, the result is ovf_sticky=1, ovf_count=1.
// - Refused inputs (in_valid=1, in_ready=0) do not affect the overflow counters.
// - Upstream must hold in_* stable while in_valid=1 and in_ready=0.
// - Reset mid-operation: all entries are discarded, level=0, counters=0. No partial state survives.
// TESTING
// - T1, basic: after reset, push sum=4'h5, cout=0, v=0.
//   -> next cycle out_valid=1, out_sum=5, out_zero=0, out_neg=0, level=1.
// - T2, flags: push sum=4'h0 then sum=4'h9, out_ready=1.
//   -> pops in order: (zero=1, neg=0), then (zero=0, neg=1).
// - T3, full: push 5 with out_ready=0, DEPTH=4.
//   -> level=4, in_ready=0 after the 4th push, 5th held.
//   -> 5th accepted only after one pop, in the cycle after that pop.
//   -> order preserved.
// - T4, simultaneous push and pop at level=2 for 10 cycles.
//   -> level stays 2; outputs equal the input stream delayed by 2 transfers.
//   -> wrap-around exercised.
// - T5, overflow: 3 pushes with v=1.
//   -> ovf_count=3, ovf_sticky=1.
//   -> ovf_clr together with a v=1 push gives ovf_count=1, ovf_sticky=1.
//   -> with CNT_W=2, 5 v=1 pushes saturate ovf_count at 3.
// - T6, reset: assert rst asynchronously between edges at level=3.
//   -> out_valid=0, level=0, in_ready=1, ovf_count=0 immediately.
//   -> first push after release appears with 1-cycle latency.

Source files
------------

// File: rtl/addsub_result_fifo.sv
// Result-capture FIFO placed after the 4-bit adder/subtractor.
// Each accepted {sum, cout, v} result is tagged with zero/negative flags
// and stored. Entries go to the consumer in order under valid/ready. A
// sticky flag and a saturating counter track results that had v=1.
//
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   in_valid/in_ready                upstream handshake
//   in_sum, in_cout, in_v            adder result
//   out_valid/out_ready              downstream handshake
//   out_sum, out_cout, out_v,
//   out_zero, out_neg                head entry (all zero when empty)
//   level                            number of occupied entries, 0..DEPTH
//   ovf_sticky, ovf_count, ovf_clr   overflow tracking and its clear
module addsub_result_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [3:0]                 in_sum,
   input  logic                       in_cout,
   input  logic                       in_v,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [3:0]                 out_sum,
   output logic                       out_cout,
   output logic                       out_v,
   output logic                       out_zero,
   output logic                       out_neg,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       ovf_sticky,
   output logic [CNT_W-1:0]           ovf_count,
   input  logic                       ovf_clr
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   typedef struct packed {
      logic       zero;
      logic       neg;
      logic       v;
      logic       cout;
      logic [3:0] sum;
   } entry_t;

   entry_t            mem [DEPTH];
   entry_t            wr_entry;
   entry_t            head;
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [LW-1:0]     level_q;
   logic              push;
   logic              pop;
   logic              ovf_push;

   // Handshake status is derived from occupancy; a full FIFO refuses a push
   // even when a pop happens in the same cycle.
   assign in_ready  = (level_q != LW'(DEPTH));
   assign out_valid = (level_q != LW'(0));
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign ovf_push  = push & in_v;
   assign level     = level_q;

   // Flags are computed once, at push time.
   always_comb begin
      wr_entry      = '0;
      wr_entry.zero = (in_sum == 4'b0000);
      wr_entry.neg  = in_sum[3];
      wr_entry.v    = in_v;
      wr_entry.cout = in_cout;
      wr_entry.sum  = in_sum;
   end

   // Storage needs no reset: contents are only observed while occupied.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_entry;
      end
   end

   // Head entry, forced to zero while empty.
   always_comb begin
      head = '0;
      if (out_valid) begin
         head = mem[rd_ptr];
      end
   end

   assign out_sum  = head.sum;
   assign out_cout = head.cout;
   assign out_v    = head.v;
   assign out_zero = head.zero;
   assign out_neg  = head.neg;

   // Pointers wrap naturally at DEPTH (a power of two).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (push && !pop) begin
            level_q <= level_q + LW'(1);
         end else if (pop && !push) begin
            level_q <= level_q - LW'(1);
         end
      end
   end

   // Overflow tracking counts accepted pushes. A clear in the same cycle as
   // an overflowing push leaves that push counted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_sticky <= 1'b0;
         ovf_count  <= '0;
      end else if (ovf_clr) begin
         ovf_sticky <= ovf_push;
         ovf_count  <= CNT_W'(ovf_push);
      end else if (ovf_push) begin
         ovf_sticky <= 1'b1;
         if (ovf_count != {CNT_W{1'b1}}) begin
            ovf_count <= ovf_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_addsub_result_fifo.sv
// Directed test of addsub_result_fifo. The main instance uses the default
// parameters. A second instance with CNT_W=2 checks counter saturation.
module tb_addsub_result_fifo;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_sum;
   logic       in_cout;
   logic       in_v;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_sum;
   logic       out_cout;
   logic       out_v;
   logic       out_zero;
   logic       out_neg;
   logic [2:0] level;
   logic       ovf_sticky;
   logic [7:0] ovf_count;
   logic       ovf_clr;

   logic       d2_in_valid;
   logic       d2_in_ready;
   logic       d2_in_v;
   logic       d2_out_valid;
   logic       d2_out_ready;
   logic [3:0] d2_out_sum;
   logic       d2_out_cout;
   logic       d2_out_v;
   logic       d2_out_zero;
   logic       d2_out_neg;
   logic [2:0] d2_level;
   logic       d2_ovf_sticky;
   logic [1:0] d2_ovf_count;

   int n_checks = 0;
   int n_fails  = 0;

   addsub_result_fifo #(.DEPTH(4), .CNT_W(8)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_sum(in_sum), .in_cout(in_cout), .in_v(in_v),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_cout(out_cout), .out_v(out_v),
      .out_zero(out_zero), .out_neg(out_neg),
      .level(level), .ovf_sticky(ovf_sticky), .ovf_count(ovf_count),
      .ovf_clr(ovf_clr)
   );

   addsub_result_fifo #(.DEPTH(4), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst),
      .in_valid(d2_in_valid), .in_ready(d2_in_ready),
      .in_sum(4'h1), .in_cout(1'b0), .in_v(d2_in_v),
      .out_valid(d2_out_valid), .out_ready(d2_out_ready),
      .out_sum(d2_out_sum), .out_cout(d2_out_cout), .out_v(d2_out_v),
      .out_zero(d2_out_zero), .out_neg(d2_out_neg),
      .level(d2_level), .ovf_sticky(d2_ovf_sticky), .ovf_count(d2_ovf_count),
      .ovf_clr(1'b0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Head entry check; zero/neg are derived here from the expected sum.
   task automatic chk_head(input string tag, input logic [3:0] s,
                           input logic c, input logic v);
      chk({tag, ".valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".sum"},   32'(out_sum),   32'(s));
      chk({tag, ".cout"},  32'(out_cout),  32'(c));
      chk({tag, ".v"},     32'(out_v),     32'(v));
      chk({tag, ".zero"},  32'(out_zero),  32'(s == 4'h0));
      chk({tag, ".neg"},   32'(out_neg),   32'(s[3]));
   endtask

   // Advance one edge; inputs are changed and outputs sampled 1ns after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_sum = 4'h0; in_cout = 1'b0; in_v = 1'b0;
      out_ready = 1'b0; ovf_clr = 1'b0;
      d2_in_valid = 1'b0; d2_in_v = 1'b0; d2_out_ready = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst.out_valid", 32'(out_valid), 32'd0);
      chk("rst.in_ready",  32'(in_ready),  32'd1);
      chk("rst.level",     32'(level),     32'd0);
      chk("rst.out_sum",   32'(out_sum),   32'd0);
      chk("rst.sticky",    32'(ovf_sticky), 32'd0);
      chk("rst.count",     32'(ovf_count), 32'd0);
      rst = 1'b0;
      step();

      // T1: single push, 1-cycle latency
      in_valid = 1'b1; in_sum = 4'h5;
      step();
      in_valid = 1'b0;
      chk_head("t1", 4'h5, 1'b0, 1'b0);
      chk("t1.level", 32'(level), 32'd1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("t1.empty", 32'(out_valid), 32'd0);
      chk("t1.zeroed_sum", 32'(out_sum), 32'd0);

      // T2: zero and negative flags, in order
      in_valid = 1'b1; in_sum = 4'h0;
      step();
      in_sum = 4'h9; in_cout = 1'b1;
      step();
      in_valid = 1'b0; in_cout = 1'b0;
      chk_head("t2.a", 4'h0, 1'b0, 1'b0);
      out_ready = 1'b1;
      step();
      chk_head("t2.b", 4'h9, 1'b1, 1'b0);
      step();
      out_ready = 1'b0;
      chk("t2.level", 32'(level), 32'd0);

      // T3: fill, refused 5th, accepted only after a pop
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_sum = 4'(i + 1);
         step();
      end
      chk("t3.level_full", 32'(level), 32'd4);
      chk("t3.in_ready",   32'(in_ready), 32'd0);
      in_sum = 4'h5;
      step();
      chk("t3.held", 32'(level), 32'd4);
      chk_head("t3.h1", 4'h1, 1'b0, 1'b0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("t3.after_pop", 32'(level), 32'd3);
      chk("t3.ready_again", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      chk("t3.fifth_in", 32'(level), 32'd4);
      out_ready = 1'b1;
      for (int i = 2; i <= 5; i++) begin
         chk_head($sformatf("t3.order%0d", i), 4'(i), 1'b0, 1'b0);
         step();
      end
      out_ready = 1'b0;
      chk("t3.drained", 32'(level), 32'd0);

      // T4: steady push+pop at level 2, stream delayed by two transfers
      in_valid = 1'b1; in_sum = 4'hA; in_cout = 1'b0;
      step();
      in_sum = 4'hB; in_cout = 1'b1;
      step();
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_sum = 4'(i); in_cout = i[0];
         if (i == 0)      chk_head("t4.s0", 4'hA, 1'b0, 1'b0);
         else if (i == 1) chk_head("t4.s1", 4'hB, 1'b1, 1'b0);
         else             chk_head($sformatf("t4.s%0d", i), 4'(i - 2), (i - 2) % 2 == 1, 1'b0);
         step();
         chk($sformatf("t4.level%0d", i), 32'(level), 32'd2);
      end
      in_valid = 1'b0;
      chk_head("t4.tail8", 4'h8, 1'b0, 1'b0);
      step();
      chk_head("t4.tail9", 4'h9, 1'b1, 1'b0);
      step();
      out_ready = 1'b0; in_cout = 1'b0;
      chk("t4.empty", 32'(level), 32'd0);
      chk("t4.no_ovf", 32'(ovf_count), 32'd0);

      // T5: overflow counting, clear collision, saturation on CNT_W=2
      in_valid = 1'b1; in_v = 1'b1; in_sum = 4'h7; out_ready = 1'b1;
      d2_in_valid = 1'b1; d2_in_v = 1'b1; d2_out_ready = 1'b1;
      repeat (3) step();
      chk("t5.count3", 32'(ovf_count), 32'd3);
      chk("t5.sticky", 32'(ovf_sticky), 32'd1);
      chk("t5.d2_count3", 32'(d2_ovf_count), 32'd3);
      ovf_clr = 1'b1;
      step();
      chk("t5.clr_push_cnt", 32'(ovf_count), 32'd1);
      chk("t5.clr_push_stk", 32'(ovf_sticky), 32'd1);
      chk("t5.d2_sat4", 32'(d2_ovf_count), 32'd3);
      in_valid = 1'b0;
      step();
      ovf_clr = 1'b0;
      chk("t5.clr_cnt", 32'(ovf_count), 32'd0);
      chk("t5.clr_stk", 32'(ovf_sticky), 32'd0);
      chk("t5.d2_sat5", 32'(d2_ovf_count), 32'd3);
      chk("t5.d2_sticky", 32'(d2_ovf_sticky), 32'd1);
      d2_in_valid = 1'b0;
      step();
      out_ready = 1'b0; d2_out_ready = 1'b0;
      chk("t5.empty", 32'(level), 32'd0);

      // T6: asynchronous reset mid-cycle at level 3
      in_valid = 1'b1; in_v = 1'b1; in_sum = 4'hC;
      repeat (3) step();
      in_valid = 1'b0; in_v = 1'b0;
      chk("t6.level3", 32'(level), 32'd3);
      chk("t6.count3", 32'(ovf_count), 32'd3);
      #2 rst = 1'b1;
      #1;
      chk("t6.out_valid", 32'(out_valid), 32'd0);
      chk("t6.level",     32'(level),     32'd0);
      chk("t6.in_ready",  32'(in_ready),  32'd1);
      chk("t6.count",     32'(ovf_count), 32'd0);
      chk("t6.sticky",    32'(ovf_sticky), 32'd0);
      step();
      rst = 1'b0;
      step();
      in_valid = 1'b1; in_sum = 4'h3;
      step();
      in_valid = 1'b0;
      chk_head("t6.first", 4'h3, 1'b0, 1'b0);
      chk("t6.level1", 32'(level), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
